// File: rtl/alu_pkg.sv
// Shared ALU encodings: ALUControl codes and execute-unit FSM states.
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_SLL   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SRL   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_XOR   = 4'b1000;
  localparam logic [3:0] ALU_SLTU  = 4'b1001;
  localparam logic [3:0] ALU_LUI12 = 4'b1010;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } alu_state_e;

  // True for the three codes handled by the serial shifter.
  function automatic logic is_shift_op(logic [3:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU operations and illegal-code detection, purely combinational.
// Shift codes pass src_a through; that is the correct result for shamt == 0,
// and non-zero shifts are handled by the serial shifter in the top level.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [3:0]      alu_ctrl_i,
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  output logic [XLEN-1:0] result_o,
  output logic            illegal_o
);

  logic slt_lt;
  logic sltu_lt;

  assign slt_lt  = $signed(src_a_i) < $signed(src_b_i);
  assign sltu_lt = src_a_i < src_b_i;

  // Decode the operation; codes 1011-1111 yield zero and flag illegal.
  always_comb begin
    result_o  = '0;
    illegal_o = 1'b0;
    case (alu_ctrl_i)
      ALU_ADD:   result_o = src_a_i + src_b_i;
      ALU_SUB:   result_o = src_a_i - src_b_i;
      ALU_AND:   result_o = src_a_i & src_b_i;
      ALU_OR:    result_o = src_a_i | src_b_i;
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:   result_o = src_a_i;
      ALU_SLT:   result_o = {{(XLEN-1){1'b0}}, slt_lt};
      ALU_XOR:   result_o = src_a_i ^ src_b_i;
      ALU_SLTU:  result_o = {{(XLEN-1){1'b0}}, sltu_lt};
      ALU_LUI12: result_o = src_b_i << 12;
      default:   illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: registered single-cycle ops plus a one-bit-per-cycle
// serial shifter for non-zero shifts, with valid/ready, busy and flush.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal_op,
  output logic            busy
);

  alu_state_e      state_q, state_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [3:0]      op_q, op_d;
  logic            sign_q, sign_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;
  logic            out_valid_q, out_valid_d;

  logic [XLEN-1:0] core_result;
  logic            core_illegal;
  logic [XLEN-1:0] acc_shifted;
  logic            accept;

  alu_comb_core #(
    .XLEN(XLEN)
  ) u_core (
    .alu_ctrl_i(alu_ctrl),
    .src_a_i   (src_a),
    .src_b_i   (src_b),
    .result_o  (core_result),
    .illegal_o (core_illegal)
  );

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q == SHIFT);
  assign accept     = in_valid & in_ready & ~flush;
  assign out_valid  = out_valid_q;
  assign result     = result_q;
  assign zero       = zero_q;
  assign illegal_op = illegal_q;

  // One-bit step of the serial shifter; SRA fills from the sign latched at acceptance.
  always_comb begin
    case (op_q)
      ALU_SLL: acc_shifted = {acc_q[XLEN-2:0], 1'b0};
      ALU_SRL: acc_shifted = {1'b0, acc_q[XLEN-1:1]};
      default: acc_shifted = {sign_q, acc_q[XLEN-1:1]};
    endcase
  end

  // Next-state: accept in IDLE, step the shifter in SHIFT, flush abandons a shift.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    sign_d      = sign_q;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    out_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_shift_op(alu_ctrl) && (src_b[4:0] != 5'd0)) begin
            state_d = SHIFT;
            acc_d   = src_a;
            cnt_d   = src_b[4:0];
            op_d    = alu_ctrl;
            sign_d  = src_a[XLEN-1];
          end else begin
            result_d    = core_result;
            zero_d      = (core_result == '0);
            illegal_d   = core_illegal;
            out_valid_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_shifted;
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            state_d     = IDLE;
            result_d    = acc_shifted;
            zero_d      = (acc_shifted == '0);
            illegal_d   = 1'b0;
            out_valid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      op_q        <= ALU_ADD;
      sign_q      <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      sign_q      <= sign_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed literal checks plus randomized traffic
// compared every cycle against a cycle-count behavioural model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_ctrl = 4'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic [31:0] result;
  logic        zero;
  logic        illegal_op;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;

  alu_exec_unit #(
    .XLEN(32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .src_a     (src_a),
    .src_b     (src_b),
    .flush     (flush),
    .out_valid (out_valid),
    .result    (result),
    .zero      (zero),
    .illegal_op(illegal_op),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Model: remaining = busy cycles still to run before the shift result appears.
  typedef struct packed {
    logic [31:0] result;
    logic [31:0] pending;
    logic        zero;
    logic        illegal;
    logic        out_valid;
    logic [5:0]  remaining;
  } model_t;

  model_t m;

  function automatic logic [31:0] ref_result(logic [3:0] c, logic [31:0] a, logic [31:0] b);
    case (c)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a << b[4:0];
      4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:    return a >> b[4:0];
      4'd7:    return $signed(a) >>> b[4:0];
      4'd8:    return a ^ b;
      4'd9:    return (a < b) ? 32'd1 : 32'd0;
      4'd10:   return b << 12;
      default: return 32'd0;
    endcase
  endfunction

  function automatic model_t model_next(model_t cur, logic r, logic v, logic fl,
                                        logic [3:0] c, logic [31:0] a, logic [31:0] b);
    model_t n;
    logic [31:0] res;
    n = cur;
    n.out_valid = 1'b0;
    if (r) begin
      n = '0;
      n.zero = 1'b1;
    end else if (cur.remaining != 0) begin
      if (fl) begin
        n.remaining = 0;
      end else begin
        n.remaining = cur.remaining - 6'd1;
        if (n.remaining == 0) begin
          n.result    = cur.pending;
          n.zero      = (cur.pending == 0);
          n.illegal   = 1'b0;
          n.out_valid = 1'b1;
        end
      end
    end else if (v && !fl) begin
      res = ref_result(c, a, b);
      if ((c == 4'd4 || c == 4'd6 || c == 4'd7) && b[4:0] != 0) begin
        n.remaining = {1'b0, b[4:0]};
        n.pending   = res;
      end else begin
        n.result    = res;
        n.zero      = (res == 0);
        n.illegal   = (c >= 4'd11);
        n.out_valid = 1'b1;
      end
    end
    return n;
  endfunction

  always @(posedge clk) m <= model_next(m, rst, in_valid, flush, alu_ctrl, src_a, src_b);

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", {31'd0, out_valid}, {31'd0, m.out_valid});
      check("busy", {31'd0, busy}, {31'd0, (m.remaining != 0)});
      check("in_ready", {31'd0, in_ready}, {31'd0, (m.remaining == 0)});
      check("result", result, m.result);
      check("zero", {31'd0, zero}, {31'd0, m.zero});
      check("illegal_op", {31'd0, illegal_op}, {31'd0, m.illegal});
    end
  end

  // Offer one op, wait for the accepting edge, then drop in_valid (now in cycle 1).
  task automatic issue(logic [3:0] c, logic [31:0] a, logic [31:0] b);
    in_valid = 1'b1;
    alu_ctrl = c;
    src_a    = a;
    src_b    = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 4))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cyc;
    logic [3:0]  b2b_c [4] = '{4'd0, 4'd8, 4'd10, 4'd2};
    logic [31:0] b2b_a [4] = '{32'd3, 32'h0000_F0F0, 32'd0, 32'h0000_00FF};
    logic [31:0] b2b_b [4] = '{32'd4, 32'h0000_FF00, 32'h0001_2345, 32'h0000_000F};
    logic [31:0] b2b_r [4] = '{32'd7, 32'h0000_0FF0, 32'h1234_5000, 32'h0000_000F};

    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk_en = 1'b1;

    // Arithmetic wrap and subtraction
    issue(4'd0, 32'hFFFF_FFFF, 32'd1);
    check("add_wrap_valid", {31'd0, out_valid}, 32'd1);
    check("add_wrap_result", result, 32'd0);
    check("add_wrap_zero", {31'd0, zero}, 32'd1);
    issue(4'd1, 32'd5, 32'd7);
    check("sub_result", result, 32'hFFFF_FFFE);
    check("sub_zero", {31'd0, zero}, 32'd0);

    // Signed vs unsigned compare
    issue(4'd5, 32'h8000_0000, 32'd1);
    check("slt_result", result, 32'd1);
    issue(4'd9, 32'h8000_0000, 32'd1);
    check("sltu_result", result, 32'd0);

    // Back-to-back single-cycle ops
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      alu_ctrl = b2b_c[i];
      src_a    = b2b_a[i];
      src_b    = b2b_b[i];
      @(posedge clk);
      #1;
      check("b2b_valid", {31'd0, out_valid}, 32'd1);
      check("b2b_result", result, b2b_r[i]);
    end
    in_valid = 1'b0;

    // SRA by 31 with stall
    issue(4'd7, 32'h8000_0000, 32'd31);
    check("sra_busy_c1", {31'd0, busy}, 32'd1);
    check("sra_ready_c1", {31'd0, in_ready}, 32'd0);
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("sra_latency", cyc, 32'd32);
    check("sra_result", result, 32'hFFFF_FFFF);

    // SLL by zero completes in one cycle
    issue(4'd4, 32'hDEAD_BEEF, 32'd0);
    check("sll0_valid", {31'd0, out_valid}, 32'd1);
    check("sll0_result", result, 32'hDEAD_BEEF);

    // SRL shamt 10 flushed in cycle 4
    issue(4'd6, 32'h1234_5678, 32'd10);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_ready", {31'd0, in_ready}, 32'd1);
    check("flush_no_valid", {31'd0, out_valid}, 32'd0);
    check("flush_result_held", result, 32'hDEAD_BEEF);
    repeat (12) @(posedge clk);
    #1;

    // Illegal code
    issue(4'd15, 32'h1111_1111, 32'h2222_2222);
    check("illegal_result", result, 32'd0);
    check("illegal_flag", {31'd0, illegal_op}, 32'd1);
    issue(4'd3, 32'h1, 32'h2);
    check("illegal_cleared", {31'd0, illegal_op}, 32'd0);

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 399) == 0);
      in_valid = ($urandom_range(0, 9) < 7);
      flush    = ($urandom_range(0, 19) == 0);
      alu_ctrl = 4'($urandom_range(0, 15));
      src_a    = pick_operand();
      src_b    = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 4)) : pick_operand();
      @(posedge clk);
      #1;
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    flush    = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
